// File: rtl/motor_pwm_pkg.sv
// Shared types and helpers for the motor PWM controller.
package motor_pwm_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DEAD  = 2'd1,
      ST_FAULT = 2'd2
   } chan_state_t;

   // Number of closed duty switches.
   function automatic int unsigned popcount(input logic [31:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < 32; i++) n += 32'(v[i]);
      return n;
   endfunction

   // Clocks of high time per closed switch.
   function automatic int unsigned duty_step(input int unsigned period, input int unsigned sw_w);
      return period / (sw_w + 1);
   endfunction

endpackage

// File: rtl/motor_pwm_chan.sv
// One H-bridge channel: duty ramp, RUN/DEAD/FAULT sequencing, overcurrent
// filter and registered bridge outputs.
module motor_pwm_chan
   import motor_pwm_pkg::*;
#(
   parameter int unsigned SW_W      = 3,
   parameter int unsigned PERIOD    = 16,
   parameter int unsigned CNT_W     = 5,
   parameter int unsigned RAMP_STEP = 0,
   parameter int unsigned DEAD_CYC  = 4,
   parameter int unsigned OC_HOLD   = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             wrap,
   input  logic [CNT_W-1:0] cnt,
   input  logic [SW_W-1:0]  sw,
   input  logic             dir,
   input  logic             isense,
   input  logic             oc_clr,
   output logic             pwm_out,
   output logic             in_a,
   output logic             in_b,
   output logic             fault,
   output logic             fault_nxt_c
);

   localparam int unsigned STEP = duty_step(PERIOD, SW_W);
   localparam int unsigned OC_W = (OC_HOLD > 1) ? $clog2(OC_HOLD) : 1;
   localparam int unsigned DC_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
   localparam logic [OC_W-1:0]  OC_TOP = OC_W'(OC_HOLD - 1);
   localparam logic [DC_W-1:0]  DC_TOP = DC_W'(DEAD_CYC - 1);
   localparam logic [CNT_W-1:0] RSTEP  = CNT_W'(RAMP_STEP);

   chan_state_t      state;
   logic [CNT_W-1:0] width;
   logic [CNT_W-1:0] target;
   logic [CNT_W-1:0] ramp_nxt;
   logic [OC_W-1:0]  oc_cnt;
   logic [DC_W-1:0]  dead_cnt;
   logic             dir_lat;
   logic             trip;
   logic             clr_ok;

   assign target      = CNT_W'(popcount(32'(sw)) * STEP);
   assign trip        = isense && (oc_cnt == OC_TOP);
   assign clr_ok      = oc_clr && !isense;
   assign fault_nxt_c = trip || ((state == ST_FAULT) && !clr_ok);

   // Width applied at the next wrap: jump to target, or step toward it.
   always_comb begin
      ramp_nxt = target;
      if (RAMP_STEP != 0) begin
         if (width < target)
            ramp_nxt = ((target - width) > RSTEP) ? width + RSTEP : target;
         else if (width > target)
            ramp_nxt = ((width - target) > RSTEP) ? width - RSTEP : target;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ST_RUN;
         width    <= '0;
         dir_lat  <= 1'b0;
         oc_cnt   <= '0;
         dead_cnt <= '0;
         pwm_out  <= 1'b0;
         in_a     <= 1'b0;
         in_b     <= 1'b1;
         fault    <= 1'b0;
      end else begin
         pwm_out <= (state == ST_RUN) && (cnt < width);
         fault   <= fault_nxt_c;

         if (!isense)
            oc_cnt <= '0;
         else if (oc_cnt != OC_TOP)
            oc_cnt <= oc_cnt + OC_W'(1);

         // Overcurrent wins over every other transition, including dead time.
         if (trip) begin
            state <= ST_FAULT;
            width <= '0;
            in_a  <= 1'b0;
            in_b  <= 1'b0;
         end else begin
            case (state)
               ST_RUN: begin
                  if (dir != dir_lat) begin
                     state    <= ST_DEAD;
                     width    <= '0;
                     dead_cnt <= DC_TOP;
                  end else if (wrap) begin
                     width <= ramp_nxt;
                  end
               end
               ST_DEAD: begin
                  if (dead_cnt == '0) begin
                     state   <= ST_RUN;
                     dir_lat <= dir;
                     width   <= '0;
                     in_a    <= dir;
                     in_b    <= ~dir;
                  end else begin
                     dead_cnt <= dead_cnt - DC_W'(1);
                  end
               end
               ST_FAULT: begin
                  if (clr_ok) begin
                     state   <= ST_RUN;
                     dir_lat <= dir;
                     width   <= '0;
                     in_a    <= dir;
                     in_b    <= ~dir;
                  end
               end
               default: state <= ST_RUN;
            endcase
         end
      end
   end

endmodule

// File: rtl/motor_pwm_ctrl.sv
// N-channel H-bridge PWM controller: shared period counter feeding one
// independent motor_pwm_chan per motor, plus the combined fault flag.
module motor_pwm_ctrl
   import motor_pwm_pkg::*;
#(
   parameter int unsigned NUM_CH    = 2,
   parameter int unsigned SW_W      = 3,
   parameter int unsigned PERIOD    = 1666667,
   parameter int unsigned CNT_W     = 21,
   parameter int unsigned RAMP_STEP = 0,
   parameter int unsigned DEAD_CYC  = 1000000,
   parameter int unsigned OC_HOLD   = 50000000
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NUM_CH*SW_W-1:0] sw,
   input  logic [NUM_CH-1:0]      dir,
   input  logic [NUM_CH-1:0]      isense,
   input  logic                   oc_clr,
   output logic [NUM_CH-1:0]      pwm_out,
   output logic [NUM_CH-1:0]      in_a,
   output logic [NUM_CH-1:0]      in_b,
   output logic [NUM_CH-1:0]      fault,
   output logic                   oc_any
);

   logic [CNT_W-1:0]  cnt;
   logic              wrap;
   logic [NUM_CH-1:0] fault_nxt;

   assign wrap = (cnt == CNT_W'(PERIOD - 1));

   always_ff @(posedge clock) begin
      if (reset) cnt <= '0;
      else       cnt <= wrap ? '0 : cnt + CNT_W'(1);
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      motor_pwm_chan #(
         .SW_W      (SW_W),
         .PERIOD    (PERIOD),
         .CNT_W     (CNT_W),
         .RAMP_STEP (RAMP_STEP),
         .DEAD_CYC  (DEAD_CYC),
         .OC_HOLD   (OC_HOLD)
      ) u_chan (
         .clock       (clock),
         .reset       (reset),
         .wrap        (wrap),
         .cnt         (cnt),
         .sw          (sw[k*SW_W +: SW_W]),
         .dir         (dir[k]),
         .isense      (isense[k]),
         .oc_clr      (oc_clr),
         .pwm_out     (pwm_out[k]),
         .in_a        (in_a[k]),
         .in_b        (in_b[k]),
         .fault       (fault[k]),
         .fault_nxt_c (fault_nxt[k])
      );
   end

   // Registered from the channels' next fault so it changes with fault.
   always_ff @(posedge clock) begin
      if (reset) oc_any <= 1'b0;
      else       oc_any <= |fault_nxt;
   end

endmodule

// File: tb/tb_motor_pwm_ctrl.sv
// Bench for motor_pwm_ctrl: two instances (jump and ramped duty) driven
// together and compared every clock against a behavioural model.
`timescale 1ns/1ps
module tb_motor_pwm_ctrl;

   localparam int NCH  = 2;
   localparam int SWW  = 3;
   localparam int PER  = 16;
   localparam int DEAD = 4;
   localparam int OCH  = 5;
   localparam int STEP = PER / (SWW + 1);
   localparam int RUN  = 0;
   localparam int DWAIT = 1;
   localparam int FLT  = 2;

   logic       clock;
   logic       reset;
   logic [5:0] sw;
   logic [1:0] dir;
   logic [1:0] isense;
   logic       oc_clr;
   logic [1:0] pwm0, a0, b0, f0;
   logic [1:0] pwm1, a1, b1, f1;
   logic       any0, any1;

   int n_checks = 0;
   int n_fail   = 0;

   int m_cnt;
   int m_st  [2][2];
   int m_w   [2][2];
   int m_dl  [2][2];
   int m_oc  [2][2];
   int m_dead[2][2];
   int e_pwm [2][2];
   int hi    [2][2];
   int t2_up [4] = '{4, 8, 12, 12};
   int t2_dn [3] = '{8, 4, 0};

   motor_pwm_ctrl #(.NUM_CH(2), .SW_W(3), .PERIOD(16), .CNT_W(5), .RAMP_STEP(0),
                    .DEAD_CYC(4), .OC_HOLD(5)) u_dut0 (
      .clock(clock), .reset(reset), .sw(sw), .dir(dir), .isense(isense), .oc_clr(oc_clr),
      .pwm_out(pwm0), .in_a(a0), .in_b(b0), .fault(f0), .oc_any(any0));

   motor_pwm_ctrl #(.NUM_CH(2), .SW_W(3), .PERIOD(16), .CNT_W(5), .RAMP_STEP(4),
                    .DEAD_CYC(4), .OC_HOLD(5)) u_dut1 (
      .clock(clock), .reset(reset), .sw(sw), .dir(dir), .isense(isense), .oc_clr(oc_clr),
      .pwm_out(pwm1), .in_a(a1), .in_b(b1), .fault(f1), .oc_any(any1));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, required finish before 2 ms");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int pop3(input logic [2:0] v);
      return int'(v[0]) + int'(v[1]) + int'(v[2]);
   endfunction

   function automatic int ramp(input int w, input int tgt, input int rs);
      if (rs == 0)  return tgt;
      if (w < tgt)  return (tgt - w > rs) ? w + rs : tgt;
      return (w - tgt > rs) ? w - rs : tgt;
   endfunction

   // Advance the model by one clock using the inputs present at the edge.
   task automatic model_step();
      bit wrap;
      wrap = (m_cnt == PER - 1);
      for (int i = 0; i < 2; i++) begin
         for (int c = 0; c < NCH; c++) begin
            int  tgt, rs;
            bit  hs, trip;
            rs = (i == 0) ? 0 : 4;
            if (reset) begin
               m_st[i][c] = RUN; m_w[i][c] = 0; m_dl[i][c] = 0;
               m_oc[i][c] = 0; m_dead[i][c] = 0; e_pwm[i][c] = 0;
            end else begin
               tgt  = pop3(sw[c*SWW +: SWW]) * STEP;
               hs   = isense[c];
               trip = hs && (m_oc[i][c] == OCH - 1);
               e_pwm[i][c] = (m_st[i][c] == RUN && m_cnt < m_w[i][c]) ? 1 : 0;
               if (trip) begin
                  m_st[i][c] = FLT; m_w[i][c] = 0;
               end else if (m_st[i][c] == RUN) begin
                  if (int'(dir[c]) != m_dl[i][c]) begin
                     m_st[i][c] = DWAIT; m_w[i][c] = 0; m_dead[i][c] = DEAD - 1;
                  end else if (wrap) begin
                     m_w[i][c] = ramp(m_w[i][c], tgt, rs);
                  end
               end else if (m_st[i][c] == DWAIT) begin
                  if (m_dead[i][c] == 0) begin
                     m_st[i][c] = RUN; m_dl[i][c] = int'(dir[c]); m_w[i][c] = 0;
                  end else begin
                     m_dead[i][c]--;
                  end
               end else if (oc_clr && !hs) begin
                  m_st[i][c] = RUN; m_dl[i][c] = int'(dir[c]); m_w[i][c] = 0;
               end
               m_oc[i][c] = hs ? ((m_oc[i][c] < OCH - 1) ? m_oc[i][c] + 1 : m_oc[i][c]) : 0;
            end
         end
      end
      m_cnt = (reset || wrap) ? 0 : m_cnt + 1;
   endtask

   task automatic compare_all();
      for (int i = 0; i < 2; i++) begin
         logic [1:0] p, a, b, f;
         logic       y;
         int         fa;
         p = (i == 0) ? pwm0 : pwm1;
         a = (i == 0) ? a0 : a1;
         b = (i == 0) ? b0 : b1;
         f = (i == 0) ? f0 : f1;
         y = (i == 0) ? any0 : any1;
         fa = 0;
         for (int c = 0; c < NCH; c++) begin
            int ef, ea, eb;
            ef = (m_st[i][c] == FLT) ? 1 : 0;
            ea = (ef == 0 && m_dl[i][c] == 1) ? 1 : 0;
            eb = (ef == 0 && m_dl[i][c] == 0) ? 1 : 0;
            check($sformatf("pwm_u%0d_c%0d", i, c),   32'(p[c]), e_pwm[i][c]);
            check($sformatf("in_a_u%0d_c%0d", i, c),  32'(a[c]), ea);
            check($sformatf("in_b_u%0d_c%0d", i, c),  32'(b[c]), eb);
            check($sformatf("fault_u%0d_c%0d", i, c), 32'(f[c]), ef);
            fa = fa | ef;
         end
         check($sformatf("oc_any_u%0d", i), 32'(y), fa);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      model_step();
      compare_all();
   endtask

   // High-time of every channel over one whole period starting at cnt==0.
   task automatic measure();
      int g;
      g = 0;
      while (m_cnt != 0 && g < 2 * PER) begin tick(); g++; end
      for (int i = 0; i < 2; i++) for (int c = 0; c < NCH; c++) hi[i][c] = 0;
      for (int t = 0; t < PER; t++) begin
         tick();
         for (int c = 0; c < NCH; c++) begin
            if (pwm0[c] === 1'b1) hi[0][c]++;
            if (pwm1[c] === 1'b1) hi[1][c]++;
         end
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_pwm0"}, 32'(pwm0), 0);  check({tag, "_pwm1"}, 32'(pwm1), 0);
      check({tag, "_ina0"}, 32'(a0), 0);    check({tag, "_ina1"}, 32'(a1), 0);
      check({tag, "_inb0"}, 32'(b0), 3);    check({tag, "_inb1"}, 32'(b1), 3);
      check({tag, "_flt0"}, 32'(f0), 0);    check({tag, "_flt1"}, 32'(f1), 0);
      check({tag, "_any0"}, 32'(any0), 0);  check({tag, "_any1"}, 32'(any1), 0);
   endtask

   initial begin
      int n, psum, c;
      int burst[2];
      reset = 1'b1; sw = '0; dir = '0; isense = '0; oc_clr = 1'b0;
      m_cnt = 0;
      tick();
      tick();
      reset = 1'b0;
      check_reset_vals("rst");

      // Jump mode: target applied at the wrap, never mid-period.
      sw = 6'b000_011;
      measure();
      check("t1_first_u0", hi[0][0], 0);
      measure();
      check("t1_w8_u0", hi[0][0], 8);
      check("t1_w8_u1", hi[1][0], 4);
      repeat (5) tick();
      sw = 6'b000_111;
      measure();
      check("t1_w12_u0", hi[0][0], 12);
      check("t1_w12_u1", hi[1][0], 12);

      // Ramp up and down by 4 clocks per period.
      sw = '0;
      do_reset();
      measure();
      check("t2_idle_u1", hi[1][0], 0);
      sw = 6'b000_111;
      measure();
      check("t2_hold0_u1", hi[1][0], 0);
      for (int k = 0; k < 4; k++) begin
         measure();
         check($sformatf("t2_up%0d_u1", k), hi[1][0], t2_up[k]);
         check($sformatf("t2_up%0d_u0", k), hi[0][0], 12);
      end
      sw = '0;
      measure();
      check("t2_hold12_u1", hi[1][0], 12);
      for (int k = 0; k < 3; k++) begin
         measure();
         check($sformatf("t2_dn%0d_u1", k), hi[1][0], t2_dn[k]);
         check($sformatf("t2_dn%0d_u0", k), hi[0][0], 0);
      end

      // Direction reversal with dead time on channel 0.
      sw = 6'b111_111;
      do_reset();
      measure();
      measure();
      check("t3_pre_u0", hi[0][0], 12);
      dir[0] = 1'b1;
      n = 0; psum = 0;
      do begin
         tick();
         n++;
         if (n >= 2 && pwm0[0] === 1'b1) psum++;
      end while (a0[0] !== 1'b1 && n < 20);
      check("t3_dead_len", n, 5);
      check("t3_dead_pwm", psum, 0);
      check("t3_inb0", 32'(b0[0]), 0);
      check("t3_ina1", 32'(a1[0]), 1);
      measure();
      check("t3_ch0_u0", hi[0][0], 12);
      check("t3_ch0_restart_u1", hi[1][0], 4);
      check("t3_ch1_u0", hi[0][1], 12);
      check("t3_ch1_u1", hi[1][1], 12);

      // Overcurrent filter: 4 high clocks pass, 5 latch.
      isense[1] = 1'b1;
      repeat (4) tick();
      isense[1] = 1'b0;
      tick();
      check("t4_nofault", 32'(f0[1]), 0);
      isense[1] = 1'b1;
      repeat (5) tick();
      check("t4_fault", 32'(f0[1]), 1);
      check("t4_any", 32'(any0), 1);
      check("t4_coast_a", 32'(a0[1]), 0);
      check("t4_coast_b", 32'(b0[1]), 0);
      tick();
      check("t4_pwm_off", 32'(pwm0[1]), 0);
      measure();
      check("t4_ch0_runs", hi[0][0], 12);
      check("t4_ch1_off", hi[0][1], 0);

      // Clear is ignored while sense is high, honoured once it drops.
      oc_clr = 1'b1;
      tick();
      oc_clr = 1'b0;
      check("t5_clr_ignored", 32'(f0[1]), 1);
      isense[1] = 1'b0;
      tick();
      oc_clr = 1'b1;
      tick();
      oc_clr = 1'b0;
      check("t5_cleared", 32'(f0[1]), 0);
      check("t5_any", 32'(any0), 0);
      check("t5_inb", 32'(b0[1]), 1);
      measure();
      check("t5_restart_u1", hi[1][1], 4);
      check("t5_run_u0", hi[0][1], 12);

      // Reset while one channel is faulted and the other in dead time.
      isense[1] = 1'b1;
      repeat (4) tick();
      dir[0] = 1'b0;
      tick();
      check("t6_faulted", 32'(f0[1]), 1);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      isense = '0;
      check_reset_vals("t6_rst");
      measure();
      check("t6_first_u0", hi[0][0], 0);
      measure();
      check("t6_resume_c0", hi[0][0], 12);
      check("t6_resume_c1", hi[0][1], 12);

      // Randomised traffic against the model.
      burst[0] = 0; burst[1] = 0;
      for (int t = 0; t < 4000; t++) begin
         if ($urandom_range(0, 39) == 0) sw = 6'($urandom);
         if ($urandom_range(0, 59) == 0) begin
            c = int'($urandom_range(0, 1));
            dir[c] = ~dir[c];
         end
         for (int k = 0; k < 2; k++) begin
            if (burst[k] == 0 && $urandom_range(0, 29) == 0) burst[k] = int'($urandom_range(1, 9));
            isense[k] = (burst[k] > 0);
            if (burst[k] > 0) burst[k]--;
         end
         oc_clr = ($urandom_range(0, 15) == 0);
         reset  = ($urandom_range(0, 1499) == 0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
